// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one synchronous memory between a scalar port and an
// L-lane vector port; ties alternate, vector bursts run to completion.
module mem_port_arbiter #(
  parameter int I = 32,
  parameter int N = 8,
  parameter int L = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_req,
  input  logic                s_we,
  input  logic [I-1:0]        s_addr,
  input  logic [I-1:0]        s_wdata,
  output logic                s_gnt,
  output logic                s_rvalid,
  output logic [I-1:0]        s_rdata,
  input  logic                v_req,
  input  logic                v_we,
  input  logic [I-1:0]        v_addr,
  input  logic [L-1:0][N-1:0] v_wdata,
  output logic                v_gnt,
  output logic                v_done,
  output logic [L-1:0][N-1:0] v_rdata,
  output logic [I-1:0]        MemAddr,
  output logic                MemWE,
  output logic [I-1:0]        MemWD,
  input  logic [I-1:0]        MemRD,
  output logic                busy,
  output logic [2:0]          fsm_state
);

  localparam int BW = (L > 1) ? $clog2(L) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(L - 1);

  typedef enum logic [2:0] {IDLE, S_ACC, S_RSP, V_BURST, V_RSP} state_t;

  state_t                state;
  logic                  last_vec;
  logic                  we_q;
  logic [I-1:0]          addr_q;
  logic [L-1:0][N-1:0]   vdata_q;
  logic [BW-1:0]         beat;
  logic [BW-1:0]         beat_nxt;
  logic                  rd_pend;
  logic [BW-1:0]         rd_idx;
  logic                  grant_s;
  logic                  grant_v;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_s  = s_req && (!v_req || last_vec);
    grant_v  = v_req && !grant_s;
    beat_nxt = beat + 1'b1;
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // All memory-side outputs are registers with async clear, so reset drops MemWE at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_vec <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      vdata_q  <= '0;
      beat     <= '0;
      rd_pend  <= 1'b0;
      rd_idx   <= '0;
      s_gnt    <= 1'b0;
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      v_gnt    <= 1'b0;
      v_done   <= 1'b0;
      v_rdata  <= '0;
      MemAddr  <= '0;
      MemWE    <= 1'b0;
      MemWD    <= '0;
    end else begin
      s_gnt    <= 1'b0;
      v_gnt    <= 1'b0;
      s_rvalid <= 1'b0;
      v_done   <= 1'b0;
      rd_pend  <= 1'b0;
      // Read data for beat k arrives one cycle after its address was presented.
      if (rd_pend) v_rdata[rd_idx] <= MemRD[N-1:0];
      case (state)
        IDLE: begin
          if (grant_s) begin
            state    <= S_ACC;
            last_vec <= 1'b0;
            s_gnt    <= 1'b1;
            we_q     <= s_we;
            addr_q   <= s_addr;
            MemAddr  <= s_addr;
            MemWE    <= s_we;
            MemWD    <= s_wdata;
          end else if (grant_v) begin
            state    <= V_BURST;
            last_vec <= 1'b1;
            v_gnt    <= 1'b1;
            beat     <= '0;
            we_q     <= v_we;
            addr_q   <= v_addr;
            vdata_q  <= v_wdata;
            MemAddr  <= v_addr;
            MemWE    <= v_we;
            MemWD    <= {{(I-N){1'b0}}, v_wdata[0]};
          end
        end
        S_ACC: begin
          state   <= S_RSP;
          MemAddr <= '0;
          MemWE   <= 1'b0;
          MemWD   <= '0;
        end
        S_RSP: begin
          if (!we_q) s_rdata <= MemRD;
          s_rvalid <= 1'b1;
          state    <= IDLE;
        end
        V_BURST: begin
          rd_pend <= !we_q;
          rd_idx  <= beat;
          if (beat == BEAT_LAST) begin
            state   <= V_RSP;
            MemAddr <= '0;
            MemWE   <= 1'b0;
            MemWD   <= '0;
          end else begin
            beat    <= beat_nxt;
            MemAddr <= addr_q + {{(I-BW){1'b0}}, beat_nxt};
            MemWD   <= {{(I-N){1'b0}}, vdata_q[beat_nxt]};
          end
        end
        V_RSP: begin
          v_done <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level timeline model with a shadow
// memory, directed scenarios, random traffic and a reset-mid-burst case.
module tb_mem_port_arbiter;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              s_req, s_we, s_gnt, s_rvalid;
  logic [31:0]       s_addr, s_wdata, s_rdata;
  logic              v_req, v_we, v_gnt, v_done;
  logic [31:0]       v_addr;
  logic [3:0][7:0]   v_wdata, v_rdata;
  logic [31:0]       MemAddr, MemWD, MemRD;
  logic              MemWE, busy;
  logic [2:0]        fsm_state;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.I(32), .N(8), .L(4)) dut (
    .clk(clk), .reset(reset),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
    .v_gnt(v_gnt), .v_done(v_done), .v_rdata(v_rdata),
    .MemAddr(MemAddr), .MemWE(MemWE), .MemWD(MemWD), .MemRD(MemRD),
    .busy(busy), .fsm_state(fsm_state)
  );

  // Synchronous memory: unwritten words hold addr ^ A5A50000.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    MemRD <= mem_rd(MemAddr);
    if (MemWE) mem[MemAddr] = MemWD;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
  endtask

  // Expected per-cycle picture, built when the model grants a request.
  typedef struct packed {
    logic            s_gnt, s_rvalid, v_gnt, v_done, busy, we;
    logic [31:0]     addr, wd;
    logic            srd_set;
    logic [31:0]     srd;
    logic [3:0]      lane_set;
    logic [3:0][7:0] lane_val;
  } exp_t;

  exp_t            sched [int];
  int              free_at;
  bit              last_vec;
  logic [31:0]     exp_srd;
  logic [3:0][7:0] exp_lanes;

  function automatic exp_t get_e(input int c);
    exp_t z;
    z = '0;
    return sched.exists(c) ? sched[c] : z;
  endfunction

  task automatic model_reset();
    sched.delete();
    free_at   = 0;
    last_vec  = 1'b1;
    exp_srd   = '0;
    exp_lanes = '0;
  endtask

  task automatic model_step(input int c);
    exp_t e;
    logic [31:0] a, w;
    bit pick_s;
    if (c < free_at || !(s_req || v_req)) return;
    pick_s = s_req && (!v_req || last_vec);
    if (pick_s) begin
      e = get_e(c+1); e.s_gnt = 1; e.busy = 1; e.addr = s_addr; e.we = s_we; e.wd = s_wdata; sched[c+1] = e;
      e = get_e(c+2); e.busy = 1; sched[c+2] = e;
      e = get_e(c+3); e.s_rvalid = 1;
      if (!s_we) begin e.srd_set = 1; e.srd = shadow_rd(s_addr); end
      sched[c+3] = e;
      if (s_we) shadow[s_addr] = s_wdata;
      free_at = c + 3; last_vec = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        a = v_addr + k;
        e = get_e(c+1+k); e.busy = 1; e.v_gnt = (k == 0); e.addr = a; e.we = v_we;
        e.wd = {24'h0, v_wdata[k]}; sched[c+1+k] = e;
        if (v_we) shadow[a] = {24'h0, v_wdata[k]};
        else begin
          w = shadow_rd(a);
          e = get_e(c+3+k); e.lane_set[k] = 1; e.lane_val[k] = w[7:0]; sched[c+3+k] = e;
        end
      end
      e = get_e(c+5); e.busy = 1; sched[c+5] = e;
      e = get_e(c+6); e.v_done = 1; sched[c+6] = e;
      free_at = c + 6; last_vec = 1'b1;
    end
  endtask

  task automatic check_cycle(input int c);
    exp_t e;
    e = get_e(c);
    if (e.srd_set) exp_srd = e.srd;
    for (int k = 0; k < 4; k++) if (e.lane_set[k]) exp_lanes[k] = e.lane_val[k];
    check_eq("s_gnt", 64'(s_gnt), 64'(e.s_gnt));
    check_eq("s_rvalid", 64'(s_rvalid), 64'(e.s_rvalid));
    check_eq("s_rdata", 64'(s_rdata), 64'(exp_srd));
    check_eq("v_gnt", 64'(v_gnt), 64'(e.v_gnt));
    check_eq("v_done", 64'(v_done), 64'(e.v_done));
    check_eq("v_rdata", 64'(v_rdata), 64'(exp_lanes));
    check_eq("mem_addr", 64'(MemAddr), 64'(e.addr));
    check_eq("mem_we", 64'(MemWE), 64'(e.we));
    check_eq("mem_wd", 64'(MemWD), 64'(e.wd));
    check_eq("busy", 64'(busy), 64'(e.busy));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_out"}, {s_gnt, s_rvalid, v_gnt, v_done, MemWE, busy}, 64'h0);
    check_eq({tag, "_mem_addr"}, 64'(MemAddr), 64'h0);
    check_eq({tag, "_mem_wd"}, 64'(MemWD), 64'h0);
    check_eq({tag, "_s_rdata"}, 64'(s_rdata), 64'h0);
    check_eq({tag, "_v_rdata"}, 64'(v_rdata), 64'h0);
  endtask

  task automatic idle_inputs();
    s_req = 0; s_we = 0; s_addr = '0; s_wdata = '0;
    v_req = 0; v_we = 0; v_addr = '0; v_wdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic drive_inputs(input int c, input int n, input int mode);
    idle_inputs();
    case (mode)
      0: begin
        s_req = ($urandom_range(0, 1) == 1); s_we = ($urandom_range(0, 1) == 1);
        s_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                             : 32'h100 + $urandom_range(0, 15);
        s_wdata = $urandom;
        v_req = ($urandom_range(0, 2) == 0); v_we = ($urandom_range(0, 1) == 1);
        v_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                             : 32'h100 + $urandom_range(0, 15);
        v_wdata = $urandom;
      end
      1: if (c == 0) begin s_req = 1; s_addr = 32'h10; end
      2: if (c == 0) begin
        v_req = 1; v_we = 1; v_addr = 32'h20; v_wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      end
      3: begin
        s_req = 1; s_addr = 32'h40 + c; s_wdata = $urandom;
        v_req = 1; v_we = 1; v_addr = 32'h80; v_wdata = $urandom;
      end
      4: if (c == 0) begin v_req = 1; v_addr = 32'hFFFF_FFFE; end
      5: begin
        v_req = (c == 0); v_addr = 32'h30;
        s_req = (c >= 2); s_we = 1; s_addr = 32'h50; s_wdata = 32'hCAFE_0050;
      end
      default: ;
    endcase
    if (c >= n) begin s_req = 0; v_req = 0; end
  endtask

  task automatic run_seq(input int n, input int mode);
    apply_reset();
    for (int c = 0; c < n + 8; c++) begin
      check_cycle(c);
      drive_inputs(c, n, mode);
      model_step(c);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic reset_mid_burst();
    logic [31:0] old22, old23;
    apply_reset();
    old22 = shadow_rd(32'h22);
    old23 = shadow_rd(32'h23);
    v_req = 1; v_we = 1; v_addr = 32'h20; v_wdata = {8'h8D, 8'h7C, 8'h6B, 8'h5A};
    @(negedge clk);
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_pre_we", 64'(MemWE), 64'h1);
    check_eq("rst_pre_addr", 64'(MemAddr), 64'h22);
    reset = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    check_eq("rst_mem20", 64'(mem_rd(32'h20)), 64'h5A);
    check_eq("rst_mem21", 64'(mem_rd(32'h21)), 64'h6B);
    check_eq("rst_mem22", 64'(mem_rd(32'h22)), 64'(old22));
    check_eq("rst_mem23", 64'(mem_rd(32'h23)), 64'(old23));
    shadow[32'h20] = 32'h5A;
    shadow[32'h21] = 32'h6B;
    @(negedge clk);
    reset = 1'b1;
    s_req = 1; s_addr = 32'h60; v_req = 1; v_addr = 32'h70;
    @(posedge clk);
    #1;
    check_eq("rst_tie_s_gnt", 64'(s_gnt), 64'h1);
    check_eq("rst_tie_v_gnt", 64'(v_gnt), 64'h0);
    check_eq("rst_tie_addr", 64'(MemAddr), 64'h60);
    @(negedge clk);
    idle_inputs();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    run_seq(1, 1);
    run_seq(1, 2);
    run_seq(12, 3);
    run_seq(1, 4);
    run_seq(10, 5);
    run_seq(400, 0);
    reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
- REQ-001 SHALL have parameter I, default 32, meaning address and data-memory word width.
- REQ-002 SHALL have parameter N, default 8, meaning vector lane width (N < I).
- REQ-003 SHALL have parameter L, default 4, meaning lanes per vector access (L >= 2).
- REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset=0 resets).
- REQ-006 SHALL have scalar ports: s_req in 1, s_we in 1, s_addr in I, s_wdata in I, s_gnt out 1, s_rvalid out 1, s_rdata out I.
- REQ-007 SHALL have vector ports: v_req in 1, v_we in 1, v_addr in I, v_wdata in [L-1:0][N-1:0], v_gnt out 1, v_done out 1, v_rdata out [L-1:0][N-1:0].
- REQ-008 SHALL have memory ports: MemAddr out I, MemWE out 1, MemWD out I, MemRD in I (synchronous memory: read data valid the cycle after the address; write commits at the edge ending a cycle with MemWE=1).
- REQ-009 SHALL have port busy, out, 1 bit: 1 whenever state != IDLE.

Function
- REQ-010 SHALL implement FSM states IDLE, S_ACC, S_RSP, V_BURST, V_RSP.
- REQ-011 SHALL accept requests only in IDLE; request inputs are sampled at the edge ending an IDLE cycle.
- REQ-012 SHALL, when exactly one of s_req/v_req is 1 in IDLE, grant that requester.
- REQ-013 SHALL, when both are 1 in IDLE, grant the requester not granted last; last-grant register resets to "vector", so scalar wins the first tie.
- REQ-014 SHALL register we, addr and wdata of the granted requester on the accepting edge; the requester may change inputs after the grant.
- REQ-015 SHALL assert s_gnt for exactly the single S_ACC cycle and v_gnt for exactly the first V_BURST cycle.
- REQ-016 SHALL sequence scalar as: S_ACC (1 cycle; MemAddr=addr, MemWE=we, MemWD=wdata), then S_RSP (1 cycle), then IDLE.
- REQ-017 SHALL, at the edge ending S_RSP, load s_rdata with MemRD on reads only (unchanged on writes), and assert s_rvalid for exactly the next cycle on reads and writes.
- REQ-018 SHALL sequence vector as: V_BURST for L cycles (beat k = 0..L-1; MemAddr=addr+k mod 2^I; MemWE=we; MemWD={zeros, lane k}), then V_RSP (1 cycle), then IDLE.
- REQ-019 SHALL, on vector reads, load v_rdata lane k with MemRD[N-1:0] at the edge ending the cycle after beat k; no lane changes on vector writes.
- REQ-020 SHALL assert v_done for exactly the cycle after V_RSP.
- REQ-021 SHALL never interrupt a burst; requests arriving during a burst are held off until IDLE.
- REQ-022 SHALL drive MemAddr=0, MemWE=0, MemWD=0 in IDLE, S_RSP and V_RSP.
- REQ-023 SHALL allow a new request to be accepted in the IDLE cycle in which s_rvalid or v_done is asserted.
- REQ-024 SHALL use a beat counter of ceil(log2(L)) bits, cleared on entry to V_BURST.

Reset
- REQ-025 SHALL, while reset=0, force state IDLE, last-grant "vector", beat counter 0, all outputs 0, and s_rdata and v_rdata 0.
- REQ-026 SHALL deassert MemWE immediately (combinationally) on reset assertion mid-access; beats already committed stay committed.
- REQ-027 SHALL begin sampling requests at the first rising edge after reset returns to 1.

Verification (I=32, N=8, L=4; cycle 0 = first cycle after reset release)
- REQ-028 SHALL cover a scalar read: s_req=1, s_addr=0x10 in cycle 0, memory word 0x10 = 0xA5A50010 -> s_gnt and MemAddr=0x10 in cycle 1; s_rvalid=1 and s_rdata=0xA5A50010 in cycle 3.
- REQ-029 SHALL cover a vector write: v_addr=0x20, lanes 0..3 = 0x11,0x22,0x33,0x44 -> MemWE=1 in cycles 1-4 with MemAddr 0x20..0x23 and MemWD 0x11,0x22,0x33,0x44; v_done in cycle 6.
- REQ-030 SHALL cover simultaneous requests held continuously: the grant order is scalar (s_gnt cycle 1), vector (v_gnt cycle 4), then scalar (s_gnt cycle 10).
- REQ-031 SHALL cover address wrap-around: vector read with v_addr=0xFFFFFFFE -> MemAddr FFFFFFFE, FFFFFFFF, 00000000, 00000001; v_rdata lanes equal the low bytes of those memory words.
- REQ-032 SHALL cover reset mid-operation: reset=0 during beat 2 of a vector write -> MemWE=0 at once, busy=0, outputs 0; only 0x20 and 0x21 are written; after release a tie goes to scalar.
- REQ-033 SHALL cover a request during a burst: v_req granted at cycle 1, s_req raised in cycle 2 -> no s_gnt until cycle 7 (IDLE in cycle 6), and the burst completes unchanged.
